fixed_divider_loader: RTL and testbench
=======================================

# fixed_divider_loader

Parametrised, self-contained fixed-point divider with byte-serial operand entry from the board switches. Operator loads dividend A and divisor B one byte at a time using a set/unlock interlock, pulses `start`, and reads the quotient Q = floor(A·2^FRAC / B) one selected byte at a time on `out`. It replaces the fixed-width controller-plus-combinational-divider pair. It adds:
- a multi-cycle restoring divider FSM;
- busy/done status;
- overflow and divide-by-zero flags;
- byte readback of any result byte.

## Interface
Parameters:
- `A_WIDTH`, 32, dividend and quotient width in bits; multiple of 8, ≥ 8.
- `B_WIDTH`, 16, divisor width in bits; multiple of 8, ≥ 8, ≤ `A_WIDTH`.
- `FRAC`, 8, fractional bits in the quotient; 0..16.
- `SEL_W`, `$clog2(A_WIDTH/8)` (minimum 1), width of the result byte select.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `init` in 1: reset, synchronous and active-high.
- `inp` in 8: switch byte to load.
- `set` in 1: load request, one byte per set/unlock cycle.
- `unlock` in 1: re-arms loading after a set.
- `start` in 1: begin a division.
- `select` in `SEL_W`: result byte index to show on `out`.
- `out` out 8: combinational view of result byte `select`.
- `byte_count` out 8: index of the next operand byte to be loaded.
- `busy` out 1: division in progress.
- `done` out 1: result valid.
- `ovf` out 1: quotient truncated.
- `dz` out 1: divisor was zero.
- `setled`, `unlockled` out 1: mirror `set` and `unlock`.

## Operation
- Operand bytes: NA = `A_WIDTH`/8, NB = `B_WIDTH`/8.
- Load order, selected by `byte_count`:
  - indices 0..NA-1 go to A, least-significant byte first;
  - indices NA..NA+NB-1 go to B, least-significant byte first.
- `byte_count` wraps to 0 after the last B byte.
- Load rule:
  - `set`=1, lock=0, state ≠ CALC: write `inp` to the selected byte, increment `byte_count`, set lock=1.
  - Otherwise, if `unlock`=1: lock=0.
  - `set` takes priority over `unlock` in the same cycle.
  - `set` during CALC is ignored and lock is unchanged.
- FSM states: IDLE, CALC, DONE.
- In IDLE or DONE with `start`=1:
  - Snapshot A and B into working registers.
  - If B=0: go to DONE, result = all ones, `dz`=1, `ovf`=0.
  - Otherwise: go to CALC. The remainder is cleared, the dividend register becomes D = {A, FRAC zeros} (width N = `A_WIDTH`+`FRAC`), and the iteration count becomes N.
- CALC, restoring division with one quotient bit per cycle:
  - Shift {rem, D} left by 1.
  - If rem ≥ B: rem -= B and the new quotient bit is 1.
  - Decrement the iteration count.
  - When the count reaches 0: go to DONE, result = low `A_WIDTH` bits of the quotient, `ovf` = OR of the upper `FRAC` quotient bits, `dz`=0.
- The remainder register is `B_WIDTH`+1 bits so the compare cannot overflow.
- `start` in CALC is ignored. Operand loading while in DONE does not alter the held result.
- `out` = result[8·`select` +: 8]. A `select` index beyond NA-1 gives 0x00.

## Timing
- Reset values: `out`=0x00, `byte_count`=0, `busy`=0, `done`=0, `ovf`=0, `dz`=0, lock=0, A=B=result=0, state IDLE.
- `init` mid-CALC aborts the division and returns to the reset values on that edge.
- `start` sampled at edge k, B ≠ 0:
  - `busy`=1 from after edge k through edge k+N, i.e. N cycles (40 at defaults).
  - `done`=1 and the result is visible after edge k+N.
- `start` with B=0: `done`=1 and `dz`=1 after edge k; `busy` never rises.
- `done`, `dz`, `ovf` hold until the next accepted `start`, which clears all three on the same edge.
- `out` follows `select` combinationally with zero latency.
- `byte_count` updates on the same edge as the byte write.

## Test plan
Defaults (32/16/8) unless noted.
- **Basic division:** load A=0x0000000A, B=0x0004, start → `busy` 40 cycles, then `done`=1; `select`=0 → 0x80, `select`=1 → 0x02, `select`=2,3 → 0x00; `ovf`=`dz`=0.
- **Fractional result:** A=1, B=3 → result 0x00000055 (85).
- **Overflow:** A=0xFFFFFFFF, B=0x0001 → result 0xFFFFFF00, `ovf`=1.
- **Divide by zero:** B=0x0000 → `done` and `dz` one cycle after `start`, result 0xFFFFFFFF, `busy` stays 0.
- **Load interlock and wrap:**
  - Hold `set` 5 cycles without `unlock` → exactly one byte loaded.
  - Six set/unlock pairs → `byte_count` returns to 0.
  - `set` during CALC → no write, `byte_count` unchanged.
- **Reset mid-run:** assert `init` at CALC cycle 20 → all outputs at reset values on the next cycle. Then reload and start → correct result. Repeat with `A_WIDTH`=16, `B_WIDTH`=8, `FRAC`=0: A=0x0064, B=0x07 → 0x000E, latency 16.

Source files
------------

// File: rtl/fixed_divider_loader.sv
// fixed_divider_loader: fixed-point divider Q = floor(A * 2^FRAC / B) with
// byte-serial operand entry (set/unlock interlock) and byte readback.
//
// Ports:
//   clock      - single clock, rising edge
//   init       - synchronous active-high reset
//   inp        - switch byte to load
//   set        - load request (one byte per set/unlock cycle)
//   unlock     - re-arms loading after a set
//   start      - begin a division (ignored while calculating)
//   select     - result byte index shown on out
//   out        - combinational view of result byte `select`
//   byte_count - index of the next operand byte to load
//   busy       - division in progress
//   done       - result valid
//   ovf        - quotient truncated to A_WIDTH bits
//   dz         - divisor was zero
//   setled     - mirrors set
//   unlockled  - mirrors unlock
module fixed_divider_loader #(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned B_WIDTH = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned SEL_W   = ((A_WIDTH / 8) > 1) ? $clog2(A_WIDTH / 8) : 1
) (
    input  logic             clock,
    input  logic             init,
    input  logic [7:0]       inp,
    input  logic             set,
    input  logic             unlock,
    input  logic             start,
    input  logic [SEL_W-1:0] select,
    output logic [7:0]       out,
    output logic [7:0]       byte_count,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             dz,
    output logic             setled,
    output logic             unlockled
);

    localparam int unsigned NA   = A_WIDTH / 8;
    localparam int unsigned NB   = B_WIDTH / 8;
    localparam int unsigned LAST = NA + NB - 1;
    localparam int unsigned N    = A_WIDTH + FRAC;
    localparam int unsigned CW   = $clog2(N + 1);
    localparam int unsigned RW   = B_WIDTH + 1;
    localparam int unsigned SW   = B_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [A_WIDTH-1:0] r_a, w_a_nxt;
    logic [B_WIDTH-1:0] r_b, w_b_nxt;
    logic [7:0]         r_byte_count, w_byte_count_nxt;
    logic               r_lock, w_lock_nxt;
    logic [B_WIDTH-1:0] r_wb, w_wb_nxt;
    logic [RW-1:0]      r_rem, w_rem_nxt;
    logic [N-1:0]       r_d, w_d_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [A_WIDTH-1:0] r_result, w_result_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_dz, w_dz_nxt;

    // One restoring step: shift {rem, D} left, trial-subtract the divisor.
    // The shifted remainder is kept one bit wider than the register so the
    // compare never overflows; the result always fits back into RW bits.
    logic [SW-1:0]      w_shift;
    logic [SW-1:0]      w_diff;
    logic               w_ge;
    logic [N-1:0]       w_q_step;
    logic [N-1:0]       w_q_hi;
    logic [CW-1:0]      w_cnt_dec;
    logic               w_calc;
    logic [7:0]         w_out;

    assign w_shift   = {r_rem, r_d[N-1]};
    assign w_diff    = w_shift - SW'(r_wb);
    assign w_ge      = (w_shift >= SW'(r_wb));
    assign w_q_step  = {r_d[N-2:0], w_ge};
    assign w_q_hi    = w_q_step >> A_WIDTH;
    assign w_cnt_dec = r_cnt - CW'(1);
    assign w_calc    = (r_state == S_CALC);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (init) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_byte_count <= '0;
            r_lock       <= 1'b0;
            r_wb         <= '0;
            r_rem        <= '0;
            r_d          <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_ovf        <= 1'b0;
            r_dz         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_byte_count <= w_byte_count_nxt;
            r_lock       <= w_lock_nxt;
            r_wb         <= w_wb_nxt;
            r_rem        <= w_rem_nxt;
            r_d          <= w_d_nxt;
            r_cnt        <= w_cnt_nxt;
            r_result     <= w_result_nxt;
            r_ovf        <= w_ovf_nxt;
            r_dz         <= w_dz_nxt;
        end
    end

    // Next-state: operand loader and divider FSM
    always_comb begin
        w_state_nxt      = r_state;
        w_a_nxt          = r_a;
        w_b_nxt          = r_b;
        w_byte_count_nxt = r_byte_count;
        w_lock_nxt       = r_lock;
        w_wb_nxt         = r_wb;
        w_rem_nxt        = r_rem;
        w_d_nxt          = r_d;
        w_cnt_nxt        = r_cnt;
        w_result_nxt     = r_result;
        w_ovf_nxt        = r_ovf;
        w_dz_nxt         = r_dz;

        // Loader: set writes one byte then locks until unlock; frozen in CALC
        if (set && !r_lock && !w_calc) begin
            for (int unsigned i = 0; i < NA; i++) begin
                if (r_byte_count == 8'(i)) begin
                    w_a_nxt[8*i +: 8] = inp;
                end
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (r_byte_count == 8'(NA + i)) begin
                    w_b_nxt[8*i +: 8] = inp;
                end
            end
            w_byte_count_nxt = (r_byte_count == 8'(LAST)) ? 8'd0 : r_byte_count + 8'd1;
            w_lock_nxt       = 1'b1;
        end else if (unlock && !(set && w_calc)) begin
            w_lock_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_ovf_nxt = 1'b0;
                    w_dz_nxt  = 1'b0;
                    if (r_b == '0) begin
                        w_state_nxt  = S_DONE;
                        w_result_nxt = '1;
                        w_dz_nxt     = 1'b1;
                    end else begin
                        w_state_nxt = S_CALC;
                        w_wb_nxt    = r_b;
                        w_rem_nxt   = '0;
                        w_d_nxt     = N'(r_a) << FRAC;
                        w_cnt_nxt   = CW'(N);
                    end
                end
            end
            S_CALC: begin
                w_rem_nxt = w_ge ? RW'(w_diff) : RW'(w_shift);
                w_d_nxt   = w_q_step;
                w_cnt_nxt = w_cnt_dec;
                if (w_cnt_dec == '0) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = w_q_step[A_WIDTH-1:0];
                    w_ovf_nxt    = |w_q_hi;
                    w_dz_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result byte mux; out-of-range select reads as zero
    always_comb begin
        w_out = 8'h00;
        for (int unsigned i = 0; i < NA; i++) begin
            if (select == SEL_W'(i)) begin
                w_out = r_result[8*i +: 8];
            end
        end
    end

    assign out        = w_out;
    assign byte_count = r_byte_count;
    assign busy       = (r_state == S_CALC);
    assign done       = (r_state == S_DONE);
    assign ovf        = r_ovf;
    assign dz         = r_dz;
    assign setled     = set;
    assign unlockled  = unlock;

endmodule

// File: tb/tb_fixed_divider_loader.sv
// Directed bench for fixed_divider_loader: default 32/16/8 instance plus a
// 16/8/0 instance for the narrow configuration.
module tb_fixed_divider_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default-parameter DUT
    logic       init, set, unlock, start;
    logic [7:0] inp;
    logic [1:0] select;
    logic [7:0] out, byte_count;
    logic       busy, done, ovf, dz, setled, unlockled;

    fixed_divider_loader dut (
        .clock(clock), .init(init), .inp(inp), .set(set), .unlock(unlock),
        .start(start), .select(select), .out(out), .byte_count(byte_count),
        .busy(busy), .done(done), .ovf(ovf), .dz(dz),
        .setled(setled), .unlockled(unlockled)
    );

    // Narrow DUT: A_WIDTH=16, B_WIDTH=8, FRAC=0
    logic       s_init, s_set, s_unlock, s_start;
    logic [7:0] s_inp;
    logic [0:0] s_select;
    logic [7:0] s_out, s_byte_count;
    logic       s_busy, s_done, s_ovf, s_dz, s_setled, s_unlockled;

    fixed_divider_loader #(.A_WIDTH(16), .B_WIDTH(8), .FRAC(0)) dut_s (
        .clock(clock), .init(s_init), .inp(s_inp), .set(s_set), .unlock(s_unlock),
        .start(s_start), .select(s_select), .out(s_out), .byte_count(s_byte_count),
        .busy(s_busy), .done(s_done), .ovf(s_ovf), .dz(s_dz),
        .setled(s_setled), .unlockled(s_unlockled)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] v);
        @(negedge clock); inp = v; set = 1'b1;
        @(negedge clock); set = 1'b0; unlock = 1'b1;
        @(negedge clock); unlock = 1'b0;
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [15:0] b);
        for (int i = 0; i < 4; i++) load_byte(a[8*i +: 8]);
        for (int i = 0; i < 2; i++) load_byte(b[8*i +: 8]);
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    // Called at the negedge after the start edge; counts busy cycles until done.
    task automatic wait_done(output int lat, output logic ok);
        int c;
        lat = 0;
        c   = 0;
        while (!done && c < 100) begin
            if (busy) lat++;
            c++;
            @(negedge clock);
        end
        ok = done;
    endtask

    task automatic read_result(output logic [31:0] r);
        for (int i = 0; i < 4; i++) begin
            select = 2'(i);
            #1;
            r[8*i +: 8] = out;
        end
        select = 2'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        select = 2'd1;
        #1;
        chk({tag, " out"}, 32'(out), 32'h0);
        chk({tag, " byte_count"}, 32'(byte_count), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " ovf"}, 32'(ovf), 32'h0);
        chk({tag, " dz"}, 32'(dz), 32'h0);
        select = 2'd0;
    endtask

    initial begin
        int          lat;
        logic        ok;
        logic [31:0] r;
        logic [31:0] held;
        logic [7:0]  sbytes [3];

        vecs[0] = '{a: 32'h0000000A, b: 16'h0004, res: 32'h00000280, ovf: 1'b0, dz: 1'b0, lat: 40};
        vecs[1] = '{a: 32'h00000001, b: 16'h0003, res: 32'h00000055, ovf: 1'b0, dz: 1'b0, lat: 40};
        vecs[2] = '{a: 32'hFFFFFFFF, b: 16'h0001, res: 32'hFFFFFF00, ovf: 1'b1, dz: 1'b0, lat: 40};
        vecs[3] = '{a: 32'h00001234, b: 16'h0000, res: 32'hFFFFFFFF, ovf: 1'b0, dz: 1'b1, lat: 0};
        vecs[4] = '{a: 32'h00010000, b: 16'hFFFF, res: 32'h00000100, ovf: 1'b0, dz: 1'b0, lat: 40};
        vecs[5] = '{a: 32'h80000000, b: 16'h0002, res: 32'h00000000, ovf: 1'b1, dz: 1'b0, lat: 40};
        vecs[6] = '{a: 32'h00000000, b: 16'h0005, res: 32'h00000000, ovf: 1'b0, dz: 1'b0, lat: 40};
        vecs[7] = '{a: 32'h12345678, b: 16'h1000, res: 32'h01234567, ovf: 1'b0, dz: 1'b0, lat: 40};

        init = 1'b1; set = 1'b0; unlock = 1'b0; start = 1'b0; inp = 8'h00; select = 2'd0;
        s_init = 1'b1; s_set = 1'b0; s_unlock = 1'b0; s_start = 1'b0; s_inp = 8'h00; s_select = 1'b0;
        repeat (2) @(negedge clock);
        init = 1'b0;
        @(negedge clock);
        chk_reset_outputs("reset");

        // Main vector table
        foreach (vecs[i]) begin
            load_ops(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d byte_count wrap", i), 32'(byte_count), 32'h0);
            pulse_start();
            wait_done(lat, ok);
            chk($sformatf("v%0d done", i), 32'(ok), 32'h1);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            read_result(r);
            chk($sformatf("v%0d result", i), r, vecs[i].res);
            chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d dz", i), 32'(dz), 32'(vecs[i].dz));
            chk($sformatf("v%0d busy idle", i), 32'(busy), 32'h0);
        end

        // Loading while DONE keeps the held result; six loads wrap byte_count
        held = vecs[7].res;
        load_byte(8'hEE);
        read_result(r);
        chk("done load keeps result", r, held);
        chk("done load byte_count", 32'(byte_count), 32'h1);
        repeat (5) load_byte(8'h00);
        chk("six loads wrap", 32'(byte_count), 32'h0);

        // Interlock: set held 5 cycles loads exactly one byte
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
        inp = 8'h5A; set = 1'b1;
        repeat (5) @(negedge clock);
        chk("setled mirror", 32'(setled), 32'h1);
        chk("held set one byte", 32'(byte_count), 32'h1);
        set = 1'b0; unlock = 1'b1;
        @(negedge clock);
        chk("unlockled mirror", 32'(unlockled), 32'h1);
        unlock = 1'b0;
        load_byte(8'h00); load_byte(8'h00); load_byte(8'h00);
        load_byte(8'h03); load_byte(8'h00);
        chk("interlock wrap", 32'(byte_count), 32'h0);

        // set during CALC: no write, byte_count unchanged; A=90,B=3 -> 0x1E00
        pulse_start();
        repeat (3) @(negedge clock);
        chk("calc busy", 32'(busy), 32'h1);
        load_byte(8'hFF);
        chk("calc set ignored", 32'(byte_count), 32'h0);
        wait_done(lat, ok);
        chk("calc set done", 32'(ok), 32'h1);
        read_result(r);
        chk("calc set result", r, 32'h00001E00);
        pulse_start();
        wait_done(lat, ok);
        read_result(r);
        chk("rerun A unchanged", r, 32'h00001E00);
        chk("rerun latency", 32'(lat), 32'd40);

        // init at CALC cycle 20 aborts to reset values on that edge
        load_ops(32'h00000001, 16'h0003);
        pulse_start();
        repeat (19) @(negedge clock);
        chk("midrun busy", 32'(busy), 32'h1);
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
        chk_reset_outputs("midrun init");
        load_ops(32'h0000000A, 16'h0004);
        pulse_start();
        wait_done(lat, ok);
        read_result(r);
        chk("after init result", r, 32'h00000280);
        chk("after init latency", 32'(lat), 32'd40);

        // Narrow instance: 100 / 7 = 14, latency 16
        @(negedge clock);
        s_init = 1'b0;
        sbytes[0] = 8'h64; sbytes[1] = 8'h00; sbytes[2] = 8'h07;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); s_inp = sbytes[i]; s_set = 1'b1;
            @(negedge clock); s_set = 1'b0; s_unlock = 1'b1;
            @(negedge clock); s_unlock = 1'b0;
        end
        chk("narrow byte_count wrap", 32'(s_byte_count), 32'h0);
        @(negedge clock); s_start = 1'b1;
        @(negedge clock); s_start = 1'b0;
        begin
            int c;
            lat = 0;
            c   = 0;
            while (!s_done && c < 100) begin
                if (s_busy) lat++;
                c++;
                @(negedge clock);
            end
        end
        chk("narrow done", 32'(s_done), 32'h1);
        chk("narrow latency", 32'(lat), 32'd16);
        s_select = 1'b0; #1; r[7:0]  = s_out;
        s_select = 1'b1; #1; r[15:8] = s_out;
        r[31:16] = 16'h0;
        chk("narrow result", r, 32'h0000000E);
        chk("narrow ovf", 32'(s_ovf), 32'h0);
        chk("narrow dz", 32'(s_dz), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
